inst_decode: RTL and testbench
==============================

# inst_decode

RV32I instruction decode stage, directly downstream of instruction fetch. Consumes the fetched PC/instruction/valid triple, splits the instruction into fields, generates the sign-extended immediate, and reads both source operands from an internal 32×32 register file written by the writeback stage. All outputs are registered: one pipeline register between fetch and execute, honouring the shared pipeline STALL and a branch FLUSH.

## Interface
- No parameters; widths fixed for RV32I: XLEN 32, 5-bit register index.
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  pipeline stall; the same net also stalls fetch.
- FLUSH  in  1  taken branch/jump; kills the instruction entering decode.
- I_PC  in  32  PC of fetched instruction.
- I_INST  in  32  fetched instruction word.
- I_VALID  in  1  I_PC/I_INST qualify this cycle.
- W_VALID  in  1  writeback write enable.
- W_RD  in  5  writeback destination register.
- W_DATA  in  32  writeback data.
- D_VALID  out  1  decoded instruction valid.
- D_PC  out  32  PC passed through.
- D_INST  out  32  raw instruction passed through.
- D_OPCODE  out  7  inst[6:0].
- D_RD, D_RS1, D_RS2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- D_FUNCT3  out  3  inst[14:12].
- D_FUNCT7  out  7  inst[31:25].
- D_IMM  out  32  sign-extended immediate for the opcode's format.
- D_RS1_DATA, D_RS2_DATA  out  32  source operand values.
- D_ILLEGAL  out  1  opcode not in RV32I base set; qualified by D_VALID.

## Operation
- Load condition: !STALL. Outputs capture decode of I_* and D_VALID <= I_VALID & !FLUSH.
- Flush: FLUSH has priority over STALL. D_VALID <= 0 next cycle; other output registers are don't-care.
- Stall (and no FLUSH): all outputs hold. Exception: if W_VALID, W_RD != 0 and W_RD == held D_RS1 (or D_RS2), the corresponding D_RS*_DATA updates to W_DATA, so the held operands never go stale.
- Immediate formats, selected by opcode:
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): {{20{i[31]}},i[31:20]}.
  - S-type (0100011): {{20{i[31]}},i[31:25],i[11:7]}.
  - B-type (1100011): {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}.
  - U-type (LUI 0110111, AUIPC 0010111): {i[31:12],12'h0}.
  - J-type (JAL 1101111): {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
  - OP 0110011, MISC-MEM 0001111, illegal: 0.
- D_ILLEGAL = 1 when opcode is none of the 11 opcodes above, which also covers inst[1:0] != 2'b11.
- Register file: two asynchronous read ports, indexed by I_INST rs1/rs2. One synchronous write port. Writes to x0 are ignored; x0 always reads 0.
- Write-through bypass: if W_VALID and W_RD == rs index and index != 0, the read returns W_DATA in the same cycle.

## Timing
- Latency 1 cycle: I_* sampled at edge N appear on D_* after edge N.
- Reset: D_VALID = 0, D_ILLEGAL = 0, all other outputs 0, all 32 registers 0.
- RST asserted mid-stall or mid-flush: reset wins; decode resumes on the first cycle after RST deasserts.
- Register write lands at the edge. A read in the following cycle sees the new value; a read in the same cycle sees it via the bypass.
- Simultaneous STALL and FLUSH: flush behaviour.
- I_VALID = 0 with !STALL: D_VALID <= 0.

## Structure
- Shared package rv32i_pkg holds the opcode localparams (OP_LUI … OP_SYSTEM) and the immediate format enum; the execute stage reuses them.
- One sub-module, reg_file: 32×32, 2R1W, bypass and x0 handling inside. Decode logic stays in inst_decode.

## Test plan
- Reset, then I_VALID=1, I_INST=0xFFF00093 (addi x1,x0,-1), I_PC=0x20000000 → next cycle D_VALID=1, D_RD=1, D_IMM=0xFFFFFFFF, D_RS1_DATA=0, D_PC=0x20000000.
- W_VALID=1, W_RD=5, W_DATA=0x12345678 in the same cycle as I_INST=0x00528133 (add x2,x5,x5) → D_RS1_DATA = D_RS2_DATA = 0x12345678 (bypass).
- Immediate formats:
  - I_INST=0xFE000EE3 (beq, offset -4) → D_IMM=0xFFFFFFFC, D_ILLEGAL=0.
  - I_INST=0x800000EF (jal) → D_IMM=0xFFF00000.
- Load add x3,x1,x2, then STALL=1 for 3 cycles with W_VALID=1, W_RD=1, W_DATA=7 on cycle 2 → outputs held, D_RS1_DATA becomes 7, D_VALID stays 1.
- STALL=1 and FLUSH=1 together with I_VALID=1 → D_VALID=0 next cycle.
- I_INST=0x0000007F → D_VALID=1, D_ILLEGAL=1. Write W_RD=0, W_DATA=5, then decode a read of x0 → 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I opcode and immediate-format definitions shared by the decode and execute stages.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_fmt = FMT_I;
      OP_STORE:                            imm_fmt = FMT_S;
      OP_BRANCH:                           imm_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    imm_fmt = FMT_U;
      OP_JAL:                              imm_fmt = FMT_J;
      default:                             imm_fmt = FMT_NONE;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: is_legal_op = 1'b1;
      default:                                         is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file: two async read ports, one sync write port,
// same-cycle write-through bypass, x0 hardwired to zero.
module reg_file
  import rv32i_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] RS1,
  input  logic [REG_W-1:0] RS2,
  output logic [XLEN-1:0]  RS1_DATA,
  output logic [XLEN-1:0]  RS2_DATA,
  input  logic             W_VALID,
  input  logic [REG_W-1:0] W_RD,
  input  logic [XLEN-1:0]  W_DATA
);

  logic [XLEN-1:0] regs [32];
  logic            wr_en;

  assign wr_en = W_VALID && (W_RD != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[W_RD] <= W_DATA;
    end
  end

  // Bypass lets decode see a value the writeback stage is committing this cycle.
  always_comb begin
    RS1_DATA = regs[RS1];
    if (RS1 == '0)                   RS1_DATA = '0;
    else if (wr_en && (W_RD == RS1)) RS1_DATA = W_DATA;
  end

  always_comb begin
    RS2_DATA = regs[RS2];
    if (RS2 == '0)                   RS2_DATA = '0;
    else if (wr_en && (W_RD == RS2)) RS2_DATA = W_DATA;
  end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: field split, immediate generation and operand read,
// registered into one pipeline stage with stall, flush and held-operand refresh.
module inst_decode
  import rv32i_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [XLEN-1:0]  I_PC,
  input  logic [XLEN-1:0]  I_INST,
  input  logic             I_VALID,
  input  logic             W_VALID,
  input  logic [REG_W-1:0] W_RD,
  input  logic [XLEN-1:0]  W_DATA,
  output logic             D_VALID,
  output logic [XLEN-1:0]  D_PC,
  output logic [XLEN-1:0]  D_INST,
  output logic [6:0]       D_OPCODE,
  output logic [REG_W-1:0] D_RD,
  output logic [REG_W-1:0] D_RS1,
  output logic [REG_W-1:0] D_RS2,
  output logic [2:0]       D_FUNCT3,
  output logic [6:0]       D_FUNCT7,
  output logic [XLEN-1:0]  D_IMM,
  output logic [XLEN-1:0]  D_RS1_DATA,
  output logic [XLEN-1:0]  D_RS2_DATA,
  output logic             D_ILLEGAL
);

  logic [6:0]        opcode;
  logic [REG_W-1:0]  rs1_idx;
  logic [REG_W-1:0]  rs2_idx;
  logic [XLEN-1:0]   rs1_rdata;
  logic [XLEN-1:0]   rs2_rdata;
  logic signed [XLEN-1:0] imm;
  logic              held_wr;

  function automatic logic signed [XLEN-1:0] build_imm(input imm_fmt_e fmt,
                                                       input logic [XLEN-1:0] i);
    case (fmt)
      FMT_I:   build_imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   build_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   build_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   build_imm = {i[31:12], 12'h000};
      FMT_J:   build_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: build_imm = '0;
    endcase
  endfunction

  assign opcode  = I_INST[6:0];
  assign rs1_idx = I_INST[19:15];
  assign rs2_idx = I_INST[24:20];
  assign imm     = build_imm(imm_fmt(opcode), I_INST);
  assign held_wr = W_VALID && (W_RD != '0);

  reg_file u_reg_file (
    .CLK      (CLK),
    .RST      (RST),
    .RS1      (rs1_idx),
    .RS2      (rs2_idx),
    .RS1_DATA (rs1_rdata),
    .RS2_DATA (rs2_rdata),
    .W_VALID  (W_VALID),
    .W_RD     (W_RD),
    .W_DATA   (W_DATA)
  );

  // Decode -> execute pipeline register
  always_ff @(posedge CLK) begin
    if (RST) begin
      D_VALID    <= 1'b0;
      D_PC       <= '0;
      D_INST     <= '0;
      D_OPCODE   <= '0;
      D_RD       <= '0;
      D_RS1      <= '0;
      D_RS2      <= '0;
      D_FUNCT3   <= '0;
      D_FUNCT7   <= '0;
      D_IMM      <= '0;
      D_RS1_DATA <= '0;
      D_RS2_DATA <= '0;
      D_ILLEGAL  <= 1'b0;
    end else if (!STALL) begin
      D_VALID    <= I_VALID && !FLUSH;
      D_PC       <= I_PC;
      D_INST     <= I_INST;
      D_OPCODE   <= opcode;
      D_RD       <= I_INST[11:7];
      D_RS1      <= rs1_idx;
      D_RS2      <= rs2_idx;
      D_FUNCT3   <= I_INST[14:12];
      D_FUNCT7   <= I_INST[31:25];
      D_IMM      <= imm;
      D_RS1_DATA <= rs1_rdata;
      D_RS2_DATA <= rs2_rdata;
      D_ILLEGAL  <= !is_legal_op(opcode);
    end else if (FLUSH) begin
      D_VALID <= 1'b0;
    end else begin
      // A stalled instruction must not keep an operand that writeback just replaced.
      if (held_wr && (W_RD == D_RS1)) D_RS1_DATA <= W_DATA;
      if (held_wr && (W_RD == D_RS2)) D_RS2_DATA <= W_DATA;
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode with hand-computed expected values.
module tb_inst_decode;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, I_VALID, W_VALID;
  logic [31:0] I_PC, I_INST, W_DATA;
  logic [4:0]  W_RD;
  logic        D_VALID, D_ILLEGAL;
  logic [31:0] D_PC, D_INST, D_IMM, D_RS1_DATA, D_RS2_DATA;
  logic [6:0]  D_OPCODE, D_FUNCT7;
  logic [4:0]  D_RD, D_RS1, D_RS2;
  logic [2:0]  D_FUNCT3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  inst_decode dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
    .W_VALID(W_VALID), .W_RD(W_RD), .W_DATA(W_DATA),
    .D_VALID(D_VALID), .D_PC(D_PC), .D_INST(D_INST), .D_OPCODE(D_OPCODE),
    .D_RD(D_RD), .D_RS1(D_RS1), .D_RS2(D_RS2), .D_FUNCT3(D_FUNCT3),
    .D_FUNCT7(D_FUNCT7), .D_IMM(D_IMM), .D_RS1_DATA(D_RS1_DATA),
    .D_RS2_DATA(D_RS2_DATA), .D_ILLEGAL(D_ILLEGAL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    I_VALID = 1'b0; I_PC = '0; I_INST = '0;
    W_VALID = 1'b0; W_RD = '0; W_DATA = '0;
    step(); step();
    RST = 1'b0;
    chk("rst_valid", {31'd0, D_VALID}, 32'd0);
    chk("rst_illegal", {31'd0, D_ILLEGAL}, 32'd0);
    chk("rst_pc", D_PC, 32'd0);
    chk("rst_imm", D_IMM, 32'd0);

    // addi x1,x0,-1
    I_VALID = 1'b1; I_INST = 32'hFFF00093; I_PC = 32'h2000_0000;
    step();
    chk("addi_valid", {31'd0, D_VALID}, 32'd1);
    chk("addi_rd", {27'd0, D_RD}, 32'd1);
    chk("addi_imm", D_IMM, 32'hFFFF_FFFF);
    chk("addi_rs1d", D_RS1_DATA, 32'd0);
    chk("addi_pc", D_PC, 32'h2000_0000);
    chk("addi_opc", {25'd0, D_OPCODE}, 32'h13);
    chk("addi_ill", {31'd0, D_ILLEGAL}, 32'd0);

    // add x2,x5,x5 with x5 written the same cycle
    W_VALID = 1'b1; W_RD = 5'd5; W_DATA = 32'h1234_5678;
    I_INST = 32'h00528133; I_PC = 32'h2000_0004;
    step();
    W_VALID = 1'b0;
    chk("byp_rs1d", D_RS1_DATA, 32'h1234_5678);
    chk("byp_rs2d", D_RS2_DATA, 32'h1234_5678);
    chk("add_rd", {27'd0, D_RD}, 32'd2);
    chk("add_rs1", {27'd0, D_RS1}, 32'd5);
    chk("add_imm", D_IMM, 32'd0);
    step();
    chk("wr_landed", D_RS1_DATA, 32'h1234_5678);

    I_INST = 32'hFE000EE3;
    step();
    chk("beq_imm", D_IMM, 32'hFFFF_FFFC);
    chk("beq_ill", {31'd0, D_ILLEGAL}, 32'd0);

    I_INST = 32'h800000EF;
    step();
    chk("jal_imm", D_IMM, 32'hFFF0_0000);

    // lui x0,0x12345 while writing x1
    W_VALID = 1'b1; W_RD = 5'd1; W_DATA = 32'h11;
    I_INST = 32'h12345037;
    step();
    chk("lui_imm", D_IMM, 32'h1234_5000);

    // sw x2,-8(x1) while writing x2
    W_RD = 5'd2; W_DATA = 32'h22;
    I_INST = 32'hFE20AC23;
    step();
    W_VALID = 1'b0;
    chk("sw_imm", D_IMM, 32'hFFFF_FFF8);
    chk("sw_f3", {29'd0, D_FUNCT3}, 32'd2);

    // add x3,x1,x2 then a 3-cycle stall
    I_INST = 32'h002081B3; I_PC = 32'h2000_0100;
    step();
    chk("add3_rs1d", D_RS1_DATA, 32'h11);
    chk("add3_rs2d", D_RS2_DATA, 32'h22);
    STALL = 1'b1; I_INST = 32'h0000007F; I_PC = 32'h2000_0200;
    step();
    chk("stall1_inst", D_INST, 32'h002081B3);
    chk("stall1_pc", D_PC, 32'h2000_0100);
    W_VALID = 1'b1; W_RD = 5'd1; W_DATA = 32'd7;
    step();
    W_VALID = 1'b0;
    chk("stall2_rs1d", D_RS1_DATA, 32'd7);
    chk("stall2_rs2d", D_RS2_DATA, 32'h22);
    chk("stall2_valid", {31'd0, D_VALID}, 32'd1);
    step();
    chk("stall3_rs1d", D_RS1_DATA, 32'd7);
    chk("stall3_inst", D_INST, 32'h002081B3);
    chk("stall3_valid", {31'd0, D_VALID}, 32'd1);

    FLUSH = 1'b1;
    step();
    chk("flush_valid", {31'd0, D_VALID}, 32'd0);
    FLUSH = 1'b0; STALL = 1'b0;

    step();
    chk("ill_valid", {31'd0, D_VALID}, 32'd1);
    chk("ill_flag", {31'd0, D_ILLEGAL}, 32'd1);
    chk("ill_imm", D_IMM, 32'd0);

    // x0 write ignored, including the bypass path
    W_VALID = 1'b1; W_RD = 5'd0; W_DATA = 32'd5;
    I_INST = 32'h00000033;
    step();
    W_VALID = 1'b0;
    chk("x0_byp", D_RS1_DATA, 32'd0);
    step();
    chk("x0_read", D_RS2_DATA, 32'd0);

    I_VALID = 1'b0;
    step();
    chk("nvalid", {31'd0, D_VALID}, 32'd0);

    // reset during stall clears outputs and registers
    I_VALID = 1'b1; I_INST = 32'h002081B3;
    step();
    STALL = 1'b1; RST = 1'b1;
    step();
    chk("rst_stall_valid", {31'd0, D_VALID}, 32'd0);
    chk("rst_stall_pc", D_PC, 32'd0);
    RST = 1'b0; STALL = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, D_VALID}, 32'd1);
    chk("post_rst_x1", D_RS1_DATA, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
